store_axi_writer: RTL
=====================

Name: store_axi_writer

Overview:
- Write-side counterpart of the MEM-stage load path. Takes a store instruction in the MEM stage (SB/SH/SW), aligns the data and generates the byte strobes.
- Issues a single-beat AXI4 write (AW/W/B) to the data-memory port.
- Stalls the pipeline until the write response arrives.
- Sits between the MEM stage and the CPU's AXI master write channels, alongside the load sign-extend path.

Parameters:
- ID_W, 4, width of AWID/BID
- AXI_ID, 4'd1, constant AWID driven on every write

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode_MEM  in  7  MEM-stage opcode; already zeroed by the hazard mux when the MEM stage is invalidated
- funct3_MEM  in  3  MEM-stage funct3
- memwrite  in  1  MEM_control[0]
- ALU_out  in  32  store byte address
- store_data  in  32  rs2 value (forwarded)
- stall_o  out  1  freeze IF..MEM while asserted
- store_done  out  1  one-cycle pulse; store retired
- store_err  out  1  one-cycle pulse, coincident with store_done; misaligned address or BRESP error
- AWID  out  ID_W  = AXI_ID
- AWADDR  out  32  {addr[31:2],2'b00}
- AWLEN  out  4  = 0
- AWSIZE  out  3  = 3'b010
- AWBURST  out  2  = 2'b01
- AWVALID  out  1
- AWREADY  in  1
- WDATA  out  32
- WSTRB  out  4
- WLAST  out  1  = WVALID
- WVALID  out  1
- WREADY  in  1
- BID  in  ID_W  ignored
- BRESP  in  2
- BVALID  in  1
- BREADY  out  1

Behaviour:
- Store request: req = memwrite & (opcode_MEM == 7'b0100011).
- Reset (async, any state): state=IDLE. AWVALID, WVALID, BREADY, store_done and store_err all 0. AWADDR, WDATA and WSTRB are 0. stall_o then follows its combinational rule below.
- Alignment, with a = ALU_out[1:0]:
  - SB (000): WSTRB = 4'b0001 << a; WDATA = {4{store_data[7:0]}}.
  - SH (001): legal only if a[0]==0; WSTRB = 4'b0011 << a; WDATA = {2{store_data[15:0]}}.
  - SW (010): legal only if a==0; WSTRB = 4'b1111; WDATA = store_data.
  - Any other funct3, or an illegal alignment, is misaligned.
- FSM states: IDLE, SEND, WAIT_B, DONE.
- IDLE:
  - With req and an aligned address: register AWADDR, WDATA and WSTRB; go to SEND.
  - With req and a misaligned address: go to DONE with the error flag set; no AXI activity.
  - Without req: stay in IDLE.
- SEND:
  - AWVALID and WVALID both rise on entry.
  - Each channel drops independently on the cycle after its own handshake (VALID & READY). Handshakes may happen in either order or in the same cycle.
  - AWADDR, WDATA and WSTRB stay stable while the corresponding VALID is high.
  - When both handshakes are complete (tracked by two done flags): go to WAIT_B.
- WAIT_B:
  - BREADY=1.
  - On BVALID: go to DONE; set the error flag when BRESP[1]==1 (SLVERR/DECERR).
  - BVALID arriving before WAIT_B is not possible by protocol; it is not sampled.
- DONE:
  - store_done=1; store_err = error flag; stall_o=0.
  - Next state is unconditionally IDLE.
  - The pipeline advances at the end of the DONE cycle, so IDLE sees the next instruction. The same store is never re-issued.
- stall_o (combinational) = (state==IDLE & req) | (state==SEND) | (state==WAIT_B).
- Latency: with AWREADY, WREADY and BVALID all immediate, the request is seen in cycle 0, SEND is cycle 1, WAIT_B is cycle 2, DONE is cycle 3. stall_o is high for cycles 0-2.
- Back-to-back stores: a second store in the MEM stage is captured in the IDLE cycle after DONE.
- Reset mid-transaction:
  - Outputs drop immediately and the transaction is abandoned.
  - The slave is reset by the same rst.

Test Plan:
- SB, ALU_out=0x0000_1003, store_data=0x1122_33AB, all READY high -> AWADDR=0x1000, WSTRB=4'b1000, WDATA=0xABAB_ABAB; store_done in cycle 3; stall_o high in cycles 0-2.
- SH, ALU_out=0x2002, store_data=0x0000_1234 -> WSTRB=4'b1100, WDATA=0x1234_1234, BRESP=OKAY -> store_err=0.
- SW at 0x3000; AWREADY held low 3 cycles, WREADY high -> WVALID high for 1 cycle, AWVALID for 4 cycles with AWADDR stable; BREADY rises only after both handshakes; stall_o held until DONE.
- SH at 0x4003 -> no AWVALID/WVALID; next cycle store_done=1 and store_err=1; stall_o high for exactly 1 cycle.
- SW with BRESP=2'b10 -> store_done=1, store_err=1.
- rst asserted in WAIT_B -> BREADY=0 immediately; after release, state is IDLE and stall_o=0 when opcode_MEM is non-store (e.g. 0x33) or memwrite=0.

Source files
------------

// File: rtl/store_axi_writer.sv
// MEM-stage store unit: aligns SB/SH/SW data, builds byte strobes and issues a
// single-beat AXI4 write, holding the pipeline until the write response returns.
module store_axi_writer #(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_MEM,
    input  logic [2:0]      funct3_MEM,
    input  logic            memwrite,
    input  logic [31:0]     ALU_out,
    input  logic [31:0]     store_data,
    output logic            stall_o,
    output logic            store_done,
    output logic            store_err,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [3:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY
);

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B, DONE} state_e;

    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bready_q, bready_d;
    logic        store_done_q, store_done_d;
    logic        store_err_q, store_err_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic        req_c;
    logic        aligned_c;
    logic [3:0]  strb_c;
    logic [31:0] data_c;
    logic        aw_hs_c;
    logic        w_hs_c;
    logic        unused_c;

    assign req_c   = memwrite && (opcode_MEM == OPC_STORE);
    assign aw_hs_c = awvalid_q && AWREADY;
    assign w_hs_c  = wvalid_q && WREADY;

    // Lane steering and alignment legality for the access size in funct3.
    always_comb begin
        aligned_c = 1'b0;
        strb_c    = 4'b0000;
        data_c    = 32'h0;
        case (funct3_MEM)
            3'b000: begin
                aligned_c = 1'b1;
                strb_c    = 4'b0001 << ALU_out[1:0];
                data_c    = {4{store_data[7:0]}};
            end
            3'b001: begin
                aligned_c = ~ALU_out[0];
                strb_c    = 4'b0011 << ALU_out[1:0];
                data_c    = {2{store_data[15:0]}};
            end
            3'b010: begin
                aligned_c = (ALU_out[1:0] == 2'b00);
                strb_c    = 4'b1111;
                data_c    = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        store_done_d = 1'b0;
        store_err_d  = 1'b0;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (aligned_c) begin
                        awaddr_d  = {ALU_out[31:2], 2'b00};
                        wdata_d   = data_c;
                        wstrb_d   = strb_c;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = SEND;
                    end else begin
                        // Misaligned: retire with error, never touch the bus.
                        store_done_d = 1'b1;
                        store_err_d  = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            SEND: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
                    bready_d = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (BVALID) begin
                    bready_d     = 1'b0;
                    store_done_d = 1'b1;
                    store_err_d  = BRESP[1];
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            store_done_q <= 1'b0;
            store_err_q  <= 1'b0;
            awaddr_q     <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            store_done_q <= store_done_d;
            store_err_q  <= store_err_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign stall_o    = ((state_q == IDLE) && req_c) || (state_q == SEND) || (state_q == WAIT_B);
    assign store_done = store_done_q;
    assign store_err  = store_err_q;
    assign AWID       = AXI_ID;
    assign AWADDR     = awaddr_q;
    assign AWLEN      = 4'd0;
    assign AWSIZE     = 3'b010;
    assign AWBURST    = 2'b01;
    assign AWVALID    = awvalid_q;
    assign WDATA      = wdata_q;
    assign WSTRB      = wstrb_q;
    assign WVALID     = wvalid_q;
    assign WLAST      = wvalid_q;
    assign BREADY     = bready_q;

    // Response ID and BRESP[0] carry no information for this single-ID master.
    assign unused_c = ^{BID, BRESP[0]};

endmodule
